// File: rtl/mips_multicycle_control_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mips_multicycle_control_pkg
// Description : Shared encodings (states, opcodes, functs, ALU codes) and the
//               per-state Moore control table for the multicycle controller.
// Revision    : 1.0 - initial release
// ============================================================================
package mips_multicycle_control_pkg;

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMREAD  = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWRITE = 4'd5,
        S_EXECUTE  = 4'd6,
        S_ALUWB    = 4'd7,
        S_BRANCH   = 4'd8,
        S_ADDIEX   = 4'd9,
        S_ADDIWB   = 4'd10,
        S_JUMP     = 4'd11
    } state_e;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;

    localparam logic [5:0] FN_ADD = 6'b100000;
    localparam logic [5:0] FN_SUB = 6'b100010;
    localparam logic [5:0] FN_AND = 6'b100100;
    localparam logic [5:0] FN_OR  = 6'b100101;
    localparam logic [5:0] FN_SLT = 6'b101010;

    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_SUB = 3'b110;
    localparam logic [2:0] ALU_AND = 3'b000;
    localparam logic [2:0] ALU_OR  = 3'b001;
    localparam logic [2:0] ALU_SLT = 3'b111;

    typedef enum logic [1:0] {
        ALUOP_ADD   = 2'd0,
        ALUOP_SUB   = 2'd1,
        ALUOP_FUNCT = 2'd2,
        ALUOP_NONE  = 2'd3
    } aluop_e;

    typedef struct packed {
        logic       pc_write_uncond;
        logic       branch;
        logic       i_or_d;
        logic       mem_write;
        logic       ir_write;
        logic       reg_write;
        logic       reg_dst;
        logic       mem_to_reg;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] pc_src;
    } ctrl_t;

    function automatic logic funct_legal(input logic [5:0] f);
        return (f == FN_ADD) || (f == FN_SUB) || (f == FN_AND) ||
               (f == FN_OR)  || (f == FN_SLT);
    endfunction

    function automatic ctrl_t moore_ctrl(input state_e s);
        ctrl_t c;
        c = '0;
        case (s)
            S_FETCH: begin
                c.ir_write        = 1'b1;
                c.alu_src_b       = 2'b01;
                c.pc_write_uncond = 1'b1;
            end
            S_DECODE:   c.alu_src_b = 2'b11;
            S_MEMADR: begin
                c.alu_src_a = 1'b1;
                c.alu_src_b = 2'b10;
            end
            S_MEMREAD:  c.i_or_d = 1'b1;
            S_MEMWB: begin
                c.reg_write  = 1'b1;
                c.mem_to_reg = 1'b1;
            end
            S_MEMWRITE: begin
                c.i_or_d    = 1'b1;
                c.mem_write = 1'b1;
            end
            S_EXECUTE:  c.alu_src_a = 1'b1;
            S_ALUWB: begin
                c.reg_write = 1'b1;
                c.reg_dst   = 1'b1;
            end
            S_BRANCH: begin
                c.alu_src_a = 1'b1;
                c.pc_src    = 2'b01;
                c.branch    = 1'b1;
            end
            S_ADDIEX: begin
                c.alu_src_a = 1'b1;
                c.alu_src_b = 2'b10;
            end
            S_ADDIWB:   c.reg_write = 1'b1;
            S_JUMP: begin
                c.pc_src          = 2'b10;
                c.pc_write_uncond = 1'b1;
            end
            default: c = '0;
        endcase
        return c;
    endfunction

    function automatic aluop_e moore_aluop(input state_e s);
        case (s)
            S_FETCH, S_DECODE, S_MEMADR, S_ADDIEX: return ALUOP_ADD;
            S_BRANCH:                              return ALUOP_SUB;
            S_EXECUTE:                             return ALUOP_FUNCT;
            default:                               return ALUOP_NONE;
        endcase
    endfunction

endpackage
`default_nettype wire

// File: rtl/mips_multicycle_control_if.sv
`default_nettype none
// ============================================================================
// Module      : mips_multicycle_control_if
// Description : Controller <-> datapath bundle: instruction fields and flags
//               in, mux selects / write enables / status out.
// Revision    : 1.0 - initial release
// ============================================================================
interface mips_multicycle_control_if #(
    parameter int COUNT_WIDTH = 32
);
    logic [5:0]             opcode;
    logic [5:0]             funct;
    logic                   zero;
    logic                   pc_write;
    logic                   i_or_d;
    logic                   mem_write;
    logic                   ir_write;
    logic                   reg_write;
    logic                   reg_dst;
    logic                   mem_to_reg;
    logic                   alu_src_a;
    logic [1:0]             alu_src_b;
    logic [2:0]             alu_control;
    logic [1:0]             pc_src;
    logic                   illegal;
    logic [3:0]             state;
    logic [COUNT_WIDTH-1:0] instr_count;

    modport master (
        input  opcode, funct, zero,
        output pc_write, i_or_d, mem_write, ir_write, reg_write, reg_dst,
               mem_to_reg, alu_src_a, alu_src_b, alu_control, pc_src,
               illegal, state, instr_count
    );

    modport slave (
        output opcode, funct, zero,
        input  pc_write, i_or_d, mem_write, ir_write, reg_write, reg_dst,
               mem_to_reg, alu_src_a, alu_src_b, alu_control, pc_src,
               illegal, state, instr_count
    );
endinterface
`default_nettype wire

// File: rtl/mips_multicycle_control_alu_decoder.sv
`default_nettype none
// ============================================================================
// Module      : mips_multicycle_control_alu_decoder
// Description : Maps the coarse ALU operation (add/sub/funct/none) and the
//               R-type funct field to the 3-bit ALU control code.
// Revision    : 1.0 - initial release
// ============================================================================
module mips_multicycle_control_alu_decoder
    import mips_multicycle_control_pkg::*;
(
    input  aluop_e     alu_op_i,
    input  logic [5:0] funct_i,
    output logic [2:0] alu_control_o
);

    always_comb begin
        alu_control_o = 3'b000;
        case (alu_op_i)
            ALUOP_ADD: alu_control_o = ALU_ADD;
            ALUOP_SUB: alu_control_o = ALU_SUB;
            ALUOP_FUNCT: begin
                case (funct_i)
                    FN_ADD:  alu_control_o = ALU_ADD;
                    FN_SUB:  alu_control_o = ALU_SUB;
                    FN_AND:  alu_control_o = ALU_AND;
                    FN_OR:   alu_control_o = ALU_OR;
                    FN_SLT:  alu_control_o = ALU_SLT;
                    default: alu_control_o = 3'b000;
                endcase
            end
            default: alu_control_o = 3'b000;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/mips_multicycle_control.sv
`default_nettype none
// ============================================================================
// Module      : mips_multicycle_control
// Description : Multicycle MIPS control FSM with registered Moore outputs,
//               illegal-encoding pulse and retired-instruction counter.
// Revision    : 1.0 - initial release
// ============================================================================
module mips_multicycle_control
    import mips_multicycle_control_pkg::*;
#(
    parameter int COUNT_WIDTH = 32
) (
    input  logic                      clk,
    input  logic                      reset,
    mips_multicycle_control_if.master bus
);

    state_e                 state_q;
    state_e                 state_d;
    ctrl_t                  ctrl_q;
    ctrl_t                  ctrl_d;
    aluop_e                 aluop_d;
    logic [2:0]             alu_control_q;
    logic [2:0]             w_alu_control_d;
    logic [COUNT_WIDTH-1:0] count_q;
    logic                   w_illegal;
    logic                   w_retire;

    always_comb begin
        state_d   = S_FETCH;
        w_illegal = 1'b0;
        case (state_q)
            S_FETCH: state_d = S_DECODE;
            S_DECODE: begin
                case (bus.opcode)
                    OP_LW, OP_SW: state_d = S_MEMADR;
                    OP_RTYPE: begin
                        if (funct_legal(bus.funct)) begin
                            state_d = S_EXECUTE;
                        end else begin
                            w_illegal = 1'b1;
                        end
                    end
                    OP_BEQ:  state_d = S_BRANCH;
                    OP_ADDI: state_d = S_ADDIEX;
                    OP_J:    state_d = S_JUMP;
                    default: w_illegal = 1'b1;
                endcase
            end
            S_MEMADR:  state_d = (bus.opcode == OP_SW) ? S_MEMWRITE : S_MEMREAD;
            S_MEMREAD: state_d = S_MEMWB;
            S_EXECUTE: state_d = S_ALUWB;
            S_ADDIEX:  state_d = S_ADDIWB;
            default:   state_d = S_FETCH;
        endcase
    end

    // Outputs are precomputed from the next state so they are flop outputs;
    // funct is already stable in the IR when DECODE hands off to EXECUTE.
    assign ctrl_d  = moore_ctrl(state_d);
    assign aluop_d = moore_aluop(state_d);

    mips_multicycle_control_alu_decoder u_alu_decoder (
        .alu_op_i      (aluop_d),
        .funct_i       (bus.funct),
        .alu_control_o (w_alu_control_d)
    );

    assign w_retire = state_q inside {S_MEMWB, S_MEMWRITE, S_ALUWB,
                                      S_BRANCH, S_ADDIWB, S_JUMP};

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= S_FETCH;
            ctrl_q        <= moore_ctrl(S_FETCH);
            alu_control_q <= ALU_ADD;
            count_q       <= '0;
        end else begin
            state_q       <= state_d;
            ctrl_q        <= ctrl_d;
            alu_control_q <= w_alu_control_d;
            if (w_retire) begin
                count_q <= count_q + COUNT_WIDTH'(1);
            end
        end
    end

    assign bus.pc_write    = ctrl_q.pc_write_uncond | (ctrl_q.branch & bus.zero);
    assign bus.i_or_d      = ctrl_q.i_or_d;
    assign bus.mem_write   = ctrl_q.mem_write;
    assign bus.ir_write    = ctrl_q.ir_write;
    assign bus.reg_write   = ctrl_q.reg_write;
    assign bus.reg_dst     = ctrl_q.reg_dst;
    assign bus.mem_to_reg  = ctrl_q.mem_to_reg;
    assign bus.alu_src_a   = ctrl_q.alu_src_a;
    assign bus.alu_src_b   = ctrl_q.alu_src_b;
    assign bus.alu_control = alu_control_q;
    assign bus.pc_src      = ctrl_q.pc_src;
    assign bus.illegal     = w_illegal;
    assign bus.state       = state_q;
    assign bus.instr_count = count_q;

endmodule
`default_nettype wire

// File: tb/tb_mips_multicycle_control.sv
`default_nettype none
// ============================================================================
// Module      : tb_mips_multicycle_control
// Description : Directed self-checking bench for the multicycle controller.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mips_multicycle_control;

    localparam int CW = 3;

    localparam logic [5:0] T_LW = 6'b100011, T_SW = 6'b101011, T_R = 6'b000000;
    localparam logic [5:0] T_BEQ = 6'b000100, T_ADDI = 6'b001000, T_J = 6'b000010;

    // {pc_write,i_or_d,mem_write,ir_write,reg_write,reg_dst,mem_to_reg,
    //  alu_src_a,alu_src_b[2],alu_control[3],pc_src[2],illegal}
    localparam logic [15:0] E_FETCH    = {8'b1001_0000, 2'b01, 3'b010, 2'b00, 1'b0};
    localparam logic [15:0] E_DECODE   = {8'b0000_0000, 2'b11, 3'b010, 2'b00, 1'b0};
    localparam logic [15:0] E_DEC_ILL  = {8'b0000_0000, 2'b11, 3'b010, 2'b00, 1'b1};
    localparam logic [15:0] E_MEMADR   = {8'b0000_0001, 2'b10, 3'b010, 2'b00, 1'b0};
    localparam logic [15:0] E_MEMREAD  = {8'b0100_0000, 2'b00, 3'b000, 2'b00, 1'b0};
    localparam logic [15:0] E_MEMWB    = {8'b0000_1010, 2'b00, 3'b000, 2'b00, 1'b0};
    localparam logic [15:0] E_MEMWRITE = {8'b0110_0000, 2'b00, 3'b000, 2'b00, 1'b0};
    localparam logic [15:0] E_EXEC_SLT = {8'b0000_0001, 2'b00, 3'b111, 2'b00, 1'b0};
    localparam logic [15:0] E_ALUWB    = {8'b0000_1100, 2'b00, 3'b000, 2'b00, 1'b0};
    localparam logic [15:0] E_BR_TAKEN = {8'b1000_0001, 2'b00, 3'b110, 2'b01, 1'b0};
    localparam logic [15:0] E_BR_NOT   = {8'b0000_0001, 2'b00, 3'b110, 2'b01, 1'b0};
    localparam logic [15:0] E_ADDIEX   = {8'b0000_0001, 2'b10, 3'b010, 2'b00, 1'b0};
    localparam logic [15:0] E_ADDIWB   = {8'b0000_1000, 2'b00, 3'b000, 2'b00, 1'b0};
    localparam logic [15:0] E_JUMP     = {8'b1000_0000, 2'b00, 3'b000, 2'b10, 1'b0};

    logic          clk = 1'b0;
    logic          reset;
    int            total = 0;
    int            bad   = 0;
    logic [CW-1:0] exp_cnt;
    logic [15:0]   ctl;

    always #5 clk = ~clk;

    mips_multicycle_control_if #(.COUNT_WIDTH(CW)) bus ();

    mips_multicycle_control #(.COUNT_WIDTH(CW)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    assign ctl = {bus.pc_write, bus.i_or_d, bus.mem_write, bus.ir_write,
                  bus.reg_write, bus.reg_dst, bus.mem_to_reg, bus.alu_src_a,
                  bus.alu_src_b, bus.alu_control, bus.pc_src, bus.illegal};

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        total++;
        if ({bus.state, ctl, bus.instr_count} !== {4'd0, E_FETCH, 3'd0}) begin
            bad++;
            $display("FAIL reset_held got=%h exp=%h", {bus.state, ctl, bus.instr_count}, {4'd0, E_FETCH, 3'd0});
        end
        reset = 1'b0;
        exp_cnt = '0;
        #1;
        total++;
        if ({bus.state, ctl, bus.instr_count} !== {4'd0, E_FETCH, 3'd0}) begin
            bad++;
            $display("FAIL reset_release got=%h exp=%h", {bus.state, ctl, bus.instr_count}, {4'd0, E_FETCH, 3'd0});
        end
    endtask

    task automatic test_lw();
        logic [19:0] exp [$];
        exp = '{{4'd0, E_FETCH}, {4'd1, E_DECODE}, {4'd2, E_MEMADR},
                {4'd3, E_MEMREAD}, {4'd4, E_MEMWB}};
        bus.opcode = T_LW; bus.funct = 6'd0; bus.zero = 1'b0;
        foreach (exp[i]) begin
            if (i > 0) tick();
            total++;
            if ({bus.state, ctl} !== exp[i]) begin
                bad++;
                $display("FAIL lw_step%0d got=%h exp=%h", i, {bus.state, ctl}, exp[i]);
            end
        end
        tick();
        exp_cnt++;
        total++;
        if (bus.instr_count !== exp_cnt) begin
            bad++;
            $display("FAIL lw_count got=%0d exp=%0d", bus.instr_count, exp_cnt);
        end
    endtask

    task automatic test_sw_slt();
        logic [19:0] exp [$];
        exp = '{{4'd0, E_FETCH}, {4'd1, E_DECODE}, {4'd2, E_MEMADR}, {4'd5, E_MEMWRITE},
                {4'd0, E_FETCH}, {4'd1, E_DECODE}, {4'd6, E_EXEC_SLT}, {4'd7, E_ALUWB}};
        foreach (exp[i]) begin
            if (i > 0) tick();
            if (i == 0) begin bus.opcode = T_SW; bus.funct = 6'b000111; end
            if (i == 4) begin bus.opcode = T_R;  bus.funct = 6'b101010; end
            total++;
            if ({bus.state, ctl} !== exp[i]) begin
                bad++;
                $display("FAIL sw_slt_step%0d got=%h exp=%h", i, {bus.state, ctl}, exp[i]);
            end
        end
        tick();
        exp_cnt = exp_cnt + 3'd2;
        total++;
        if ({bus.state, bus.instr_count} !== {4'd0, exp_cnt}) begin
            bad++;
            $display("FAIL sw_slt_count got=%h exp=%h", {bus.state, bus.instr_count}, {4'd0, exp_cnt});
        end
    endtask

    task automatic test_rtype_functs();
        logic [5:0] fn  [4] = '{6'b100000, 6'b100010, 6'b100100, 6'b100101};
        logic [2:0] alu [4] = '{3'b010, 3'b110, 3'b000, 3'b001};
        for (int k = 0; k < 4; k++) begin
            bus.opcode = T_R; bus.funct = fn[k];
            tick(); tick();
            total++;
            if ({bus.state, bus.alu_control} !== {4'd6, alu[k]}) begin
                bad++;
                $display("FAIL rtype_funct%0d got=%h exp=%h", k, {bus.state, bus.alu_control}, {4'd6, alu[k]});
            end
            tick(); tick();
            exp_cnt++;
        end
    endtask

    task automatic test_addi();
        logic [19:0] exp [$];
        exp = '{{4'd0, E_FETCH}, {4'd1, E_DECODE}, {4'd9, E_ADDIEX}, {4'd10, E_ADDIWB}};
        bus.opcode = T_ADDI; bus.funct = 6'b101010;
        foreach (exp[i]) begin
            if (i > 0) tick();
            total++;
            if ({bus.state, ctl} !== exp[i]) begin
                bad++;
                $display("FAIL addi_step%0d got=%h exp=%h", i, {bus.state, ctl}, exp[i]);
            end
        end
        tick();
        exp_cnt++;
    endtask

    task automatic test_beq();
        for (int z = 1; z >= 0; z--) begin
            bus.opcode = T_BEQ; bus.funct = 6'd0; bus.zero = z[0];
            tick(); tick();
            total++;
            if ({bus.state, ctl} !== {4'd8, (z == 1) ? E_BR_TAKEN : E_BR_NOT}) begin
                bad++;
                $display("FAIL beq_z%0d got=%h exp=%h", z, {bus.state, ctl},
                         {4'd8, (z == 1) ? E_BR_TAKEN : E_BR_NOT});
            end
            bus.zero = ~z[0];
            #1;
            total++;
            if (bus.pc_write !== ~z[0]) begin
                bad++;
                $display("FAIL beq_zero_comb%0d got=%b exp=%b", z, bus.pc_write, ~z[0]);
            end
            bus.zero = 1'b0;
            tick();
            exp_cnt++;
            total++;
            if ({bus.state, bus.instr_count} !== {4'd0, exp_cnt}) begin
                bad++;
                $display("FAIL beq_retire%0d got=%h exp=%h", z, {bus.state, bus.instr_count}, {4'd0, exp_cnt});
            end
        end
    endtask

    task automatic test_jump();
        bus.opcode = T_J;
        tick(); tick();
        total++;
        if ({bus.state, ctl} !== {4'd11, E_JUMP}) begin
            bad++;
            $display("FAIL jump got=%h exp=%h", {bus.state, ctl}, {4'd11, E_JUMP});
        end
        tick();
        exp_cnt++;
    endtask

    task automatic test_illegal();
        logic [5:0] op [2] = '{6'b111111, 6'b000000};
        for (int k = 0; k < 2; k++) begin
            bus.opcode = op[k]; bus.funct = 6'b000000;
            tick();
            total++;
            if ({bus.state, ctl} !== {4'd1, E_DEC_ILL}) begin
                bad++;
                $display("FAIL illegal%0d_decode got=%h exp=%h", k, {bus.state, ctl}, {4'd1, E_DEC_ILL});
            end
            tick();
            total++;
            if ({bus.state, ctl, bus.instr_count} !== {4'd0, E_FETCH, exp_cnt}) begin
                bad++;
                $display("FAIL illegal%0d_after got=%h exp=%h", k, {bus.state, ctl, bus.instr_count},
                         {4'd0, E_FETCH, exp_cnt});
            end
        end
    endtask

    task automatic test_reset_mid();
        bus.opcode = T_LW;
        repeat (4) tick();
        total++;
        if ({bus.state, bus.reg_write} !== {4'd4, 1'b1}) begin
            bad++;
            $display("FAIL midreset_pre got=%h exp=%h", {bus.state, bus.reg_write}, {4'd4, 1'b1});
        end
        #2;
        reset = 1'b1;
        #1;
        exp_cnt = '0;
        total++;
        if ({bus.reg_write, bus.state, bus.instr_count} !== {1'b0, 4'd0, 3'd0}) begin
            bad++;
            $display("FAIL midreset_async got=%h exp=%h", {bus.reg_write, bus.state, bus.instr_count},
                     {1'b0, 4'd0, 3'd0});
        end
        tick();
        reset = 1'b0;
        #1;
        total++;
        if ({bus.state, ctl, bus.instr_count} !== {4'd0, E_FETCH, 3'd0}) begin
            bad++;
            $display("FAIL midreset_release got=%h exp=%h", {bus.state, ctl, bus.instr_count},
                     {4'd0, E_FETCH, 3'd0});
        end
    endtask

    task automatic test_wrap();
        bus.opcode = T_J;
        for (int k = 1; k <= 8; k++) begin
            repeat (3) tick();
            if (k == 7) begin
                total++;
                if (bus.instr_count !== 3'd7) begin
                    bad++;
                    $display("FAIL wrap_max got=%0d exp=7", bus.instr_count);
                end
            end
        end
        total++;
        if (bus.instr_count !== 3'd0) begin
            bad++;
            $display("FAIL wrap_zero got=%0d exp=0", bus.instr_count);
        end
    endtask

    initial begin
        reset = 1'b1;
        bus.opcode = 6'd0; bus.funct = 6'd0; bus.zero = 1'b0;
        exp_cnt = '0;
        repeat (2) @(posedge clk);
        #1;
        test_reset();
        test_lw();
        test_sw_slt();
        test_rtype_functs();
        test_addi();
        test_beq();
        test_jump();
        test_illegal();
        test_reset_mid();
        test_wrap();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
